// File: rtl/mem_port_arbiter.sv
// Two-port (core / debug-loader) memory arbiter with round-robin tie break
// and a per-access ready timeout. All outputs are registered.
//
// state  | meaning
// IDLE   | no access in flight, arbitrating requests
// BUSY_C | core access driven to memory, waiting for mem_ready
// BUSY_D | debug access driven to memory, waiting for mem_ready
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_err,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_C = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [7:0] TMO_CNT = 8'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;   // 1: debug port won the last grant
    logic [7:0]        cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              c_gnt_q, c_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              c_rvalid_q, c_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic              c_err_q, c_err_d;
    logic              d_err_q, d_err_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              start_c, start_d;
    logic [DATA_W-1:0] rdata_n;

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        c_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        c_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        c_err_d     = 1'b0;
        d_err_d     = 1'b0;
        c_rdata_d   = c_rdata_q;
        d_rdata_d   = d_rdata_q;
        start_c     = 1'b0;
        start_d     = 1'b0;
        rdata_n     = '0;

        case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time is served.
                start_c = c_req && (!d_req || last_d_q);
                start_d = d_req && (!c_req || !last_d_q);
                if (start_c) begin
                    state_d     = BUSY_C;
                    last_d_d    = 1'b0;
                    cnt_d       = '0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = c_we;
                    mem_addr_d  = c_addr;
                    mem_wdata_d = c_wdata;
                    c_gnt_d     = 1'b1;
                end else if (start_d) begin
                    state_d     = BUSY_D;
                    last_d_d    = 1'b1;
                    cnt_d       = '0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    d_gnt_d     = 1'b1;
                end
            end

            BUSY_C, BUSY_D: begin
                // mem_ready takes priority over a timeout in the same cycle.
                if (mem_ready || (cnt_q == TMO_CNT)) begin
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    rdata_n  = (mem_ready && !mem_we_q) ? mem_rdata : '0;
                    if (state_q == BUSY_D) begin
                        d_rvalid_d = 1'b1;
                        d_err_d    = !mem_ready;
                        d_rdata_d  = rdata_n;
                    end else begin
                        c_rvalid_d = 1'b1;
                        c_err_d    = !mem_ready;
                        c_rdata_d  = rdata_n;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            c_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            c_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            c_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
            c_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            c_gnt_q     <= c_gnt_d;
            d_gnt_q     <= d_gnt_d;
            c_rvalid_q  <= c_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            c_err_q     <= c_err_d;
            d_err_q     <= d_err_d;
            c_rdata_q   <= c_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign c_gnt     = c_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign c_rvalid  = c_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign c_err     = c_err_q;
    assign d_err     = d_err_q;
    assign c_rdata   = c_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter MAX_WAIT, default 15, cycles to wait for mem_ready before timeout; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 c_req / d_req  input  1  access request from the core / debug-loader port.
REQ-007 c_we / d_we  input  1  1 = write, 0 = read.
REQ-008 c_addr / d_addr  input  ADDR_W  access address.
REQ-009 c_wdata / d_wdata  input  DATA_W  write data.
REQ-010 c_gnt / d_gnt  output  1  one-cycle pulse: request accepted.
REQ-011 c_rvalid / d_rvalid  output  1  one-cycle pulse: access complete.
REQ-012 c_rdata / d_rdata  output  DATA_W  read data, valid with rvalid.
REQ-013 c_err / d_err  output  1  timeout flag, valid with rvalid.
REQ-014 mem_en  output  1  memory access active.
REQ-015 mem_we, mem_addr, mem_wdata  output  1/ADDR_W/DATA_W  latched command to memory.
REQ-016 mem_rdata  input  DATA_W  memory read data.
REQ-017 mem_ready  input  1  memory completes the current access this cycle.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY_C and BUSY_D; all outputs registered.
REQ-019 IDLE: if exactly one req is high, SHALL go to the matching BUSY state at the next edge.
REQ-020 IDLE with both req high: SHALL grant the port that was not granted last (round-robin via a last_grant register).
REQ-021 On the IDLE->BUSY edge, SHALL latch the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata, set mem_en=1, clear the wait counter, and pulse the winner's gnt for exactly the first BUSY cycle.
REQ-022 Requesters SHALL hold req and the command stable until gnt; the arbiter SHALL ignore the command after latching.
REQ-023 A req still high after its rvalid SHALL be treated as a new request.
REQ-024 BUSY with mem_ready=1: next edge SHALL return to IDLE, mem_en=0, pulse the owner's rvalid for one cycle, and set err=0.
REQ-025 On that edge, rdata SHALL capture mem_rdata for reads and be 0 for writes; rdata holds until the next rvalid for that port.
REQ-026 BUSY with mem_ready=0: wait counter (8 bits) SHALL increment each cycle.
REQ-027 When the counter equals MAX_WAIT-1 and mem_ready=0, next edge SHALL return to IDLE, pulse rvalid with err=1, rdata=0, mem_en=0.
REQ-028 If mem_ready=1 in the timeout cycle, SHALL complete normally (ready wins, err=0).
REQ-029 mem_ready SHALL be ignored in IDLE.
REQ-030 Minimum latency: req sampled at cycle 0 -> gnt/mem_en at cycle 1 -> mem_ready at cycle 1 -> rvalid at cycle 2; back-to-back grant earliest at cycle 3.
REQ-031 last_grant SHALL update only on an IDLE->BUSY transition.
REQ-032 Non-owner gnt/rvalid/err SHALL stay 0 throughout a transaction.

Reset
REQ-033 rst=1 SHALL force IDLE; all gnt, rvalid, err and mem_en = 0; mem_we=0; mem_addr, mem_wdata, rdata = 0; counter = 0; last_grant = D (core wins first tie).
REQ-034 rst mid-transaction SHALL abort with no rvalid; a late mem_ready SHALL be ignored.

Verification
REQ-035 Core read 0x100 alone, mem_ready on 1st BUSY cycle, mem_rdata=0xDEADBEEF -> c_gnt at cycle 1, c_rvalid at cycle 2, c_rdata=0xDEADBEEF, c_err=0.
REQ-036 c_req and d_req both held from reset, each access ready after 2 cycles -> grants alternate C,D,C,D; no port granted twice in a row.
REQ-037 Debug write 0x20<-0x55, mem_ready never asserted, MAX_WAIT=15 -> d_rvalid with d_err=1 exactly 15 cycles after the grant cycle, then mem_en=0.
REQ-038 mem_ready asserted in the timeout cycle -> rvalid with err=0 and the captured data.
REQ-039 rst pulsed in the 2nd BUSY cycle, then mem_ready=1 -> no rvalid, IDLE, mem_en=0; next tie grants core.
REQ-040 mem_ready pulsed in IDLE, no req -> no outputs change.
